// File: rtl/dispatch_ctrl_if.sv
// Decoder/ROB/RS-facing signal bundle for dispatch_ctrl.
// master drives decoder and status inputs; slave is the controller.
interface dispatch_ctrl_if #(
  parameter int PKT_W = 128,
  parameter int TAG_W = 5,
  parameter int CNT_W = 3
);
  logic             rdy;
  logic             inValid;
  logic [1:0]       inClass;
  logic [PKT_W-1:0] inPkt;
  logic             inReady;
  logic             aluFull;
  logic             brFull;
  logic             lsFull;
  logic             commitEn;
  logic             flush;
  logic             dispatchEn;
  logic             ALUen;
  logic             BranchEn;
  logic             LSen;
  logic [PKT_W-1:0] dispPkt;
  logic [TAG_W-1:0] ROBfreeTag;
  logic             robFull;
  logic [CNT_W-1:0] qCount;

  modport master (
    output rdy, inValid, inClass, inPkt, aluFull, brFull, lsFull, commitEn, flush,
    input  inReady, dispatchEn, ALUen, BranchEn, LSen, dispPkt, ROBfreeTag, robFull, qCount
  );

  modport slave (
    input  rdy, inValid, inClass, inPkt, aluFull, brFull, lsFull, commitEn, flush,
    output inReady, dispatchEn, ALUen, BranchEn, LSen, dispPkt, ROBfreeTag, robFull, qCount
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Decode-to-dispatch sequencer: packet FIFO, ROB tag allocator, RS-aware release.
// Define DISPATCH_BYPASS_EN to let a packet skip the empty queue and dispatch the same cycle.
module dispatch_ctrl #(
  parameter int DEPTH    = 4,
  parameter int PKT_W    = 128,
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 5
) (
  input  logic           clk,
  input  logic           rst,
  dispatch_ctrl_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ROB_PW = $clog2(ROB_SIZE);
  localparam int ROBC_W = ROB_PW + 1;
  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_BR  = 2'd1;
  localparam logic [1:0] CLS_LS  = 2'd2;
  localparam logic [1:0] CLS_NOP = 2'd3;

  logic [PKT_W-1:0]  r_pkt [DEPTH];
  logic [1:0]        r_cls [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ROBC_W-1:0] r_rob_count;
  logic [ROB_PW-1:0] r_alloc_ptr;

  logic             w_rob_full;
  logic             w_q_empty;
  logic [1:0]       w_head_cls;
  logic [PKT_W-1:0] w_head_pkt;
  logic             w_go;
  logic             w_in_ready;
  logic             w_q_disp;
  logic             w_q_drop;
  logic             w_byp_disp;
  logic             w_byp_drop;
  logic             w_deq;
  logic             w_enq;
  logic             w_dispatch;
  logic [1:0]       w_disp_cls;
  logic             w_commit;

  function automatic logic unit_full(input logic [1:0] cls, input logic alu_f,
                                     input logic br_f, input logic ls_f);
    case (cls)
      CLS_ALU: return alu_f;
      CLS_BR:  return br_f;
      CLS_LS:  return ls_f;
      default: return 1'b1;
    endcase
  endfunction

  assign w_rob_full = (r_rob_count == ROBC_W'(ROB_SIZE));
  assign w_q_empty  = (r_count == '0);
  assign w_head_cls = r_cls[r_rd_ptr];
  assign w_head_pkt = r_pkt[r_rd_ptr];
  assign w_go       = bus.rdy && !bus.flush;
  // inReady looks only at occupancy, so a full queue refuses input even while draining
  assign w_in_ready = bus.rdy && (r_count < CNT_W'(DEPTH));

  assign w_q_disp = !w_q_empty && (w_head_cls != CLS_NOP) && !w_rob_full && w_go &&
                    !unit_full(w_head_cls, bus.aluFull, bus.brFull, bus.lsFull);
  assign w_q_drop = !w_q_empty && (w_head_cls == CLS_NOP) && w_go;

`ifdef DISPATCH_BYPASS_EN
  logic w_byp_cand;
  assign w_byp_cand = w_q_empty && bus.inValid && w_go;
  assign w_byp_disp = w_byp_cand && (bus.inClass != CLS_NOP) && !w_rob_full &&
                      !unit_full(bus.inClass, bus.aluFull, bus.brFull, bus.lsFull);
  assign w_byp_drop = w_byp_cand && (bus.inClass == CLS_NOP);
`else
  assign w_byp_disp = 1'b0;
  assign w_byp_drop = 1'b0;
`endif

  assign w_deq      = w_q_disp || w_q_drop;
  assign w_enq      = bus.inValid && w_in_ready && !bus.flush && !w_byp_disp && !w_byp_drop;
  assign w_dispatch = w_q_disp || w_byp_disp;
  assign w_disp_cls = w_byp_disp ? bus.inClass : w_head_cls;
  assign w_commit   = bus.commitEn && (r_rob_count != '0);

  assign bus.inReady    = w_in_ready;
  assign bus.dispatchEn = w_dispatch;
  assign bus.ALUen      = w_dispatch && (w_disp_cls == CLS_ALU);
  assign bus.BranchEn   = w_dispatch && (w_disp_cls == CLS_BR);
  assign bus.LSen       = w_dispatch && (w_disp_cls == CLS_LS);
  assign bus.dispPkt    = w_byp_disp ? bus.inPkt : w_head_pkt;
  assign bus.ROBfreeTag = w_rob_full ? TAG_W'(ROB_SIZE) : TAG_W'(r_alloc_ptr);
  assign bus.robFull    = w_rob_full;
  assign bus.qCount     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_rob_count <= '0;
      r_alloc_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pkt[i] <= '0;
        r_cls[i] <= '0;
      end
    end else if (bus.rdy) begin
      if (bus.flush) begin
        // storage is left as-is; pointers and counts alone define validity
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_count     <= '0;
        r_rob_count <= '0;
        r_alloc_ptr <= '0;
      end else begin
        if (w_enq) begin
          r_pkt[r_wr_ptr] <= bus.inPkt;
          r_cls[r_wr_ptr] <= bus.inClass;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_dispatch) begin
          r_alloc_ptr <= r_alloc_ptr + 1'b1;
        end
        case ({w_dispatch, w_commit})
          2'b10:   r_rob_count <= r_rob_count + 1'b1;
          2'b01:   r_rob_count <= r_rob_count - 1'b1;
          default: r_rob_count <= r_rob_count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl with a dispatch scoreboard (packet, unit, ROB tag).
module tb_dispatch_ctrl;
  localparam int PKT_W    = 128;
  localparam int TAG_W    = 5;
  localparam int DEPTH    = 4;
  localparam int ROB_SIZE = 16;
  localparam int CNT_W    = 3;

  typedef struct {
    logic [PKT_W-1:0] pkt;
    logic [1:0]       cls;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   m_alloc;
  int   n_checks = 0;
  int   n_err    = 0;
  int   pkt_seq  = 0;

  always #5 clk = ~clk;

  dispatch_ctrl_if #(.PKT_W(PKT_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  dispatch_ctrl #(.DEPTH(DEPTH), .PKT_W(PKT_W), .ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] new_pkt();
    pkt_seq++;
    return {$urandom(), $urandom(), $urandom(), 32'(pkt_seq)};
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] cls);
    case (cls)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic [PKT_W-1:0] p, input logic [1:0] c);
    sb.push_back('{pkt: p, cls: c});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sample combinational outputs for the current cycle and score any dispatch
  task automatic look();
    exp_t e;
    #1;
    if (bus.dispatchEn === 1'b1) begin
      chk("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("disp_pkt", bus.dispPkt, e.pkt);
        chk("disp_unit", {bus.ALUen, bus.BranchEn, bus.LSen}, onehot(e.cls));
        chk("disp_tag", bus.ROBfreeTag, TAG_W'(m_alloc % ROB_SIZE));
        m_alloc++;
      end
    end else begin
      chk("idle_units", {bus.ALUen, bus.BranchEn, bus.LSen}, 3'b000);
    end
  endtask

  task automatic stream(input int n, input logic [1:0] cls);
    logic [PKT_W-1:0] p;
    for (int i = 0; i < n; i++) begin
      p           = new_pkt();
      bus.inValid = 1'b1;
      bus.inClass = cls;
      bus.inPkt   = p;
      if (cls != 2'd3) push(p, cls);
      look();
      tick();
    end
    bus.inValid = 1'b0;
    look();
    tick();
  endtask

  task automatic idle_inputs();
    bus.rdy      = 1'b1;
    bus.inValid  = 1'b0;
    bus.inClass  = 2'd0;
    bus.inPkt    = '0;
    bus.aluFull  = 1'b0;
    bus.brFull   = 1'b0;
    bus.lsFull   = 1'b0;
    bus.commitEn = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    m_alloc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PKT_W-1:0] p;
    do_reset();
    #1;
    chk("rst_dispatchEn", bus.dispatchEn, 1'b0);
    chk("rst_units", {bus.ALUen, bus.BranchEn, bus.LSen}, 3'b000);
    chk("rst_robFull", bus.robFull, 1'b0);
    chk("rst_tag", bus.ROBfreeTag, 5'd0);
    chk("rst_qCount", bus.qCount, 3'd0);
    chk("rst_inReady", bus.inReady, 1'b1);
    chk("rst_dispPkt", bus.dispPkt, '0);

`ifdef DISPATCH_BYPASS_EN
    do_reset();
    p = new_pkt();
    bus.inValid = 1'b1;
    bus.inClass = 2'd1;
    bus.inPkt   = p;
    push(p, 2'd1);
    look();
    chk("byp_en", bus.dispatchEn, 1'b1);
    chk("byp_qCount", bus.qCount, 3'd0);
    tick();
    bus.inClass = 2'd3;
    bus.inPkt   = new_pkt();
    look();
    chk("byp_nop_en", bus.dispatchEn, 1'b0);
    tick();
    bus.inValid = 1'b0;
    #1;
    chk("byp_qCount_after", bus.qCount, 3'd0);
    chk("byp_tag_after", bus.ROBfreeTag, 5'd1);
`else
    // single ALU packet: one cycle of queue latency, tag 0
    do_reset();
    p = new_pkt();
    bus.inValid = 1'b1;
    bus.inClass = 2'd0;
    bus.inPkt   = p;
    push(p, 2'd0);
    look();
    chk("t1_no_same_cycle", bus.dispatchEn, 1'b0);
    tick();
    bus.inValid = 1'b0;
    look();
    chk("t1_dispatchEn", bus.dispatchEn, 1'b1);
    tick();
    #1;
    chk("t1_qCount", bus.qCount, 3'd0);
    chk("t1_next_tag", bus.ROBfreeTag, 5'd1);

    // full queue behind a busy LS station; full queue refuses input while draining
    do_reset();
    bus.lsFull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = new_pkt();
      bus.inValid = 1'b1;
      bus.inClass = 2'd2;
      bus.inPkt   = p;
      push(p, 2'd2);
      look();
      tick();
    end
    bus.inPkt = new_pkt();
    #1;
    chk("t2_qCount_full", bus.qCount, 3'd4);
    chk("t2_inReady_full", bus.inReady, 1'b0);
    chk("t2_stalled", bus.dispatchEn, 1'b0);
    bus.lsFull = 1'b0;
    look();
    chk("t2_disp0", bus.dispatchEn, 1'b1);
    tick();
    bus.inValid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      look();
      chk("t2_disp_seq", bus.dispatchEn, 1'b1);
      tick();
    end
    look();
    chk("t2_drained", bus.qCount, 3'd0);
    chk("t2_no_extra", bus.dispatchEn, 1'b0);
    chk("t2_sb_empty", sb.size() == 0, 1'b1);

    // rdy low freezes a ready head
    do_reset();
    bus.aluFull = 1'b1;
    stream(1, 2'd0);
    bus.aluFull = 1'b0;
    bus.rdy     = 1'b0;
    look();
    chk("rdy_dispatchEn", bus.dispatchEn, 1'b0);
    chk("rdy_inReady", bus.inReady, 1'b0);
    tick();
    chk("rdy_qCount_frozen", bus.qCount, 3'd1);
    bus.rdy = 1'b1;
    look();
    chk("rdy_resume", bus.dispatchEn, 1'b1);
    tick();

    // fill the ROB, stall, then commit one and see the tag wrap
    do_reset();
    stream(17, 2'd0);
    chk("t3_robFull", bus.robFull, 1'b1);
    chk("t3_tag_free", bus.ROBfreeTag, 5'd16);
    chk("t3_qCount", bus.qCount, 3'd1);
    chk("t3_dispPkt_held", bus.dispPkt, sb[0].pkt);
    bus.commitEn = 1'b1;
    look();
    chk("t3_stall_on_full", bus.dispatchEn, 1'b0);
    tick();
    bus.commitEn = 1'b0;
    look();
    chk("t3_after_commit", bus.dispatchEn, 1'b1);
    tick();
    chk("t3_full_again", bus.robFull, 1'b1);
    chk("t3_sb_empty", sb.size() == 0, 1'b1);

    // dispatch+commit together at robCount 5; NOP consumes no tag
    do_reset();
    stream(5, 2'd0);
    p = new_pkt();
    bus.inValid = 1'b1;
    bus.inClass = 2'd0;
    bus.inPkt   = p;
    push(p, 2'd0);
    look();
    tick();
    bus.inValid  = 1'b0;
    bus.commitEn = 1'b1;
    look();
    chk("t4_disp_commit", bus.dispatchEn, 1'b1);
    tick();
    bus.commitEn = 1'b0;
    stream(1, 2'd3);
    chk("t4_nop_dequeued", bus.qCount, 3'd0);
    chk("t4_nop_no_tag", bus.ROBfreeTag, 5'd6);
    stream(10, 2'd0);
    chk("t4_rob15_notfull", bus.robFull, 1'b0);
    chk("t4_tag_wrapped", bus.ROBfreeTag, 5'd0);
    stream(1, 2'd0);
    chk("t4_rob16_full", bus.robFull, 1'b1);

    // flush with queued packets and a live incoming packet
    do_reset();
    stream(7, 2'd0);
    bus.aluFull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.inValid = 1'b1;
      bus.inClass = 2'd0;
      bus.inPkt   = new_pkt();
      look();
      tick();
    end
    bus.inValid = 1'b0;
    #1;
    chk("t5_qCount_3", bus.qCount, 3'd3);
    chk("t5_tag_7", bus.ROBfreeTag, 5'd7);
    bus.aluFull = 1'b0;
    bus.flush   = 1'b1;
    bus.inValid = 1'b1;
    bus.inPkt   = new_pkt();
    look();
    chk("t5_flush_blocks", bus.dispatchEn, 1'b0);
    tick();
    bus.flush   = 1'b0;
    bus.inValid = 1'b0;
    m_alloc     = 0;
    look();
    chk("t5_qCount_0", bus.qCount, 3'd0);
    chk("t5_tag_0", bus.ROBfreeTag, 5'd0);
    chk("t5_robFull", bus.robFull, 1'b0);
    chk("t5_pkt_lost", bus.dispatchEn, 1'b0);
    bus.commitEn = 1'b1;
    tick();
    bus.commitEn = 1'b0;
    stream(15, 2'd0);
    chk("t5_rob15", bus.robFull, 1'b0);
    chk("t5_tag15", bus.ROBfreeTag, 5'd15);
    stream(1, 2'd0);
    chk("t5_rob16", bus.robFull, 1'b1);
    chk("t5_sb_empty", sb.size() == 0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
